// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver into a show-ahead byte FIFO; 8E1 framing when UART_RX_PARITY_EN is defined, else 8N1.
// A good byte is pushed the cycle after its stop sample; a push into a full FIFO without rd_en is dropped and flags overrun.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  logic            rx_meta, rxs, rxs_d;
  logic [2:0]      state;
  logic [TW-1:0]   tcnt;
  logic            tick, enter_start;
  logic [3:0]      scnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;
  logic            push, par_ok, frame_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign enter_start = (state == IDLE) && rxs_d && !rxs;
  assign tick        = (tcnt == TW'(DIV - 1));
  assign frame_set   = (state == STOP) && tick && (scnt == 4'd15) && !rxs;

  // Tick phase is realigned to the start edge so mid-bit sampling is exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tcnt <= '0;
    else if (enter_start || tick)  tcnt <= '0;
    else                           tcnt <= tcnt + 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_set;
  assign par_set = (state == PARITY) && tick && (scnt == 4'd15) && (^{rxs, shreg});
  assign par_ok  = !par_bad;
`else
  assign par_ok  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      scnt  <= 4'd0;
      bidx  <= 3'd0;
      shreg <= 8'd0;
      push  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: if (enter_start) begin
          state <= START;
          scnt  <= 4'd0;
        end
        START: if (tick) begin
          if (scnt == 4'd7) begin
            scnt  <= 4'd0;
            bidx  <= 3'd0;
            state <= rxs ? IDLE : DATA;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        DATA: if (tick) begin
          scnt <= scnt + 1'b1;
          if (scnt == 4'd15) begin
            shreg <= {rxs, shreg[7:1]};
            bidx  <= bidx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bidx == 3'd7) state <= PARITY;
`else
            if (bidx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          scnt <= scnt + 1'b1;
          if (scnt == 4'd15) begin
            par_bad <= par_set;
            state   <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          scnt <= scnt + 1'b1;
          if (scnt == 4'd15) begin
            if (rxs) begin
              state <= IDLE;
              push  <= par_ok;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            dout_hold;
  logic                  do_push, do_pop, drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? dout_hold : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout_hold <= 8'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!empty) dout_hold <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        parity_err <= 1'b0;
    else if (par_set) parity_err <= 1'b1;
    else if (clr_err) parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 16 clocks per bit, 4-entry FIFO; expected bytes are queued at send time and checked on pop.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, rx, rd_en, clr_err;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun, parity_err;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .empty(empty), .full(full), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted pop is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: popped %0h, scoreboard holds nothing", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input bit chk, input bit rdp);
    rx = 1'b0;
    repeat (16) cyc();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) cyc();
    end
    rx = stopb;
    repeat (11) cyc();
    if (chk) check("empty_before_push", empty, 1'b1);
    if (rdp) rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    if (chk) check("empty_after_push", empty, 1'b0);
    repeat (4) cyc();
    rx = 1'b1;
  endtask

  task automatic pop();
    int n = 0;
    while (empty && n < 400) begin
      cyc();
      n++;
    end
    if (empty) begin
      tests++;
      fails++;
      $display("FAIL pop_timeout: empty stayed 1 for %0d cycles, required 0", n);
    end else begin
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) cyc();
    check("rst_dout", dout, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    reset = 1'b0;
    repeat (20) cyc();

    // 1: two good bytes
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("t1_head", dout, 8'hA5);
    pop();
    check("t1_second", dout, 8'h3C);
    pop();
    check("t1_empty", empty, 1'b1);
    check("t1_hold", dout, 8'h3C);
    check("t1_frame_err", frame_err, 1'b0);
    check("t1_overrun", overrun, 1'b0);

    // 2: short glitch in IDLE
    rx = 1'b0;
    repeat (4) cyc();
    rx = 1'b1;
    repeat (30) cyc();
    check("t2_empty", empty, 1'b1);
    check("t2_frame_err", frame_err, 1'b0);

    // 3: bad stop bit, long low line, then a good byte
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) cyc();
    check("t3_frame_err", frame_err, 1'b1);
    check("t3_no_store", empty, 1'b1);
    rx = 1'b1;
    repeat (20) cyc();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    check("t3_head", dout, 8'h12);
    pop();
    check("t3_empty", empty, 1'b1);
    pulse_clr();
    check("t3_clr", frame_err, 1'b0);

    // 4: overflow with no reads
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 1'b0, 1'b0);
      if (b == 3) check("t4_not_full", full, 1'b0);
      if (b == 4) begin
        check("t4_full", full, 1'b1);
        check("t4_no_overrun_yet", overrun, 1'b0);
      end
    end
    check("t4_overrun", overrun, 1'b1);
    check("t4_still_full", full, 1'b1);
    repeat (4) pop();
    check("t4_empty", empty, 1'b1);
    pulse_clr();
    check("t4_clr", overrun, 1'b0);

    // 5: push and pop together while full
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 1'b0, 1'b0);
    end
    check("t5_full", full, 1'b1);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1);
    check("t5_overrun", overrun, 1'b0);
    check("t5_full_after", full, 1'b1);
    repeat (4) pop();
    check("t5_empty", empty, 1'b1);
    check("t5_last", dout, 8'h77);

    // 6: reset mid-frame with two bytes buffered
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    check("t6_held", empty, 1'b0);
    rx = 1'b0;
    repeat (16) cyc();
    rx = 1'b1;
    repeat (40) cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    check("t6_empty", empty, 1'b1);
    check("t6_dout", dout, 8'h00);
    check("t6_frame_err", frame_err, 1'b0);
    check("t6_overrun", overrun, 1'b0);
    repeat (30) cyc();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check("t6_head", dout, 8'h81);
    pop();
    check("t6_final_empty", empty, 1'b1);
    check("scoreboard_leftover", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
